// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle from vga_timing_gen to the pixel-colour stages.
// frame_cnt exists only when VGA_TIMING_FRAME_CNT_EN is defined.
interface vga_timing_gen_if;
  logic       pix_ce;
  logic [9:0] x;
  logic [9:0] y;
  logic       hsync;
  logic       vsync;
  logic       video_on;
  logic       line_start;
  logic       frame_start;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] frame_cnt;

  modport master (
    output pix_ce, x, y, hsync, vsync, video_on, line_start, frame_start, frame_cnt
  );
  modport slave (
    input pix_ce, x, y, hsync, vsync, video_on, line_start, frame_start, frame_cnt
  );
`else
  modport master (
    output pix_ce, x, y, hsync, vsync, video_on, line_start, frame_start
  );
  modport slave (
    input pix_ce, x, y, hsync, vsync, video_on, line_start, frame_start
  );
`endif
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-rate divider, x/y counters, registered sync/blank/pulses.
// Define VGA_TIMING_FRAME_CNT_EN to add the 16-bit frame counter output.
module vga_timing_gen #(
  parameter int unsigned CLK_DIV   = 2,
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33,
  parameter bit          SYNC_POL  = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  vga_timing_gen_if.master  vga_o
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [3:0] DivLast  = 4'(CLK_DIV - 1);
  localparam logic [9:0] HLast    = 10'(H_TOTAL - 1);
  localparam logic [9:0] VLast    = 10'(V_TOTAL - 1);
  localparam logic [9:0] HVis     = 10'(H_VISIBLE);
  localparam logic [9:0] VVis     = 10'(V_VISIBLE);
  localparam logic [9:0] HSyncBeg = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HSyncEnd = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VSyncBeg = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VSyncEnd = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  logic       tick;
  logic [3:0] div_q, div_d;
  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic       pix_ce_q, pix_ce_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       video_on_q, video_on_d;
  logic       line_start_q, line_start_d;
  logic       frame_start_q, frame_start_d;

  always_comb begin
    tick  = (div_q == DivLast);
    div_d = tick ? 4'd0 : div_q + 4'd1;
    x_d   = x_q;
    y_d   = y_q;
    if (tick) begin
      if (x_q == HLast) begin
        x_d = 10'd0;
        y_d = (y_q == VLast) ? 10'd0 : y_q + 10'd1;
      end else begin
        x_d = x_q + 10'd1;
      end
    end
    // Decode from next-state counters so the registered flags line up with x/y.
    hsync_d       = ((x_d >= HSyncBeg) && (x_d <= HSyncEnd)) ? SYNC_POL : ~SYNC_POL;
    vsync_d       = ((y_d >= VSyncBeg) && (y_d <= VSyncEnd)) ? SYNC_POL : ~SYNC_POL;
    video_on_d    = (x_d < HVis) && (y_d < VVis);
    pix_ce_d      = tick;
    line_start_d  = tick && (x_d == 10'd0);
    frame_start_d = line_start_d && (y_d == 10'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q         <= 4'd0;
      x_q           <= 10'd0;
      y_q           <= 10'd0;
      pix_ce_q      <= 1'b0;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      video_on_q    <= 1'b1;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      x_q           <= x_d;
      y_q           <= y_d;
      pix_ce_q      <= pix_ce_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    frame_cnt_d = frame_start_d ? frame_cnt_q + 16'd1 : frame_cnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt_q <= 16'd0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign vga_o.frame_cnt = frame_cnt_q;
`endif

  assign vga_o.pix_ce      = pix_ce_q;
  assign vga_o.x           = x_q;
  assign vga_o.y           = y_q;
  assign vga_o.hsync       = hsync_q;
  assign vga_o.vsync       = vsync_q;
  assign vga_o.video_on    = video_on_q;
  assign vga_o.line_start  = line_start_q;
  assign vga_o.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: full 640x480 line timing, plus reduced 16x8 rasters for frame-level checks.
module tb_vga_timing_gen;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  vga_timing_gen_if big_if ();
  vga_timing_gen_if sm_if ();
  vga_timing_gen_if one_if ();

  vga_timing_gen #(.CLK_DIV(2)) u_big (
    .clk   (clk),
    .rst   (rst),
    .vga_o (big_if.master)
  );

  // Small raster: 16 x 8 total, hsync low x=10..12, vsync low y=5..6.
  vga_timing_gen #(
    .CLK_DIV(2), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
  ) u_sm (
    .clk   (clk),
    .rst   (rst),
    .vga_o (sm_if.master)
  );

  vga_timing_gen #(
    .CLK_DIV(1), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
  ) u_one (
    .clk   (clk),
    .rst   (rst),
    .vga_o (one_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    int k;
    int n;
    int von;
    int vlow;
    int hlow;
    int hlow_v;
    int ls;
    int pce;
    logic [9:0] px;
    logic [9:0] py;
    n_cmp = 0;
    n_bad = 0;

    // Reset state
    rst = 1'b1;
    step();
    step();
    check("rst_x", big_if.x, 0);
    check("rst_y", big_if.y, 0);
    check("rst_hsync", big_if.hsync, 1);
    check("rst_vsync", big_if.vsync, 1);
    check("rst_video_on", big_if.video_on, 1);
    check("rst_pix_ce", big_if.pix_ce, 0);
    check("rst_line_start", big_if.line_start, 0);
    check("rst_frame_start", big_if.frame_start, 0);

    // First tick lands CLK_DIV clocks after release
    rst = 1'b0;
    step();
    check("rel1_x", big_if.x, 0);
    check("rel1_pix_ce", big_if.pix_ce, 0);
    check("rel1_one_x", one_if.x, 1);
    check("rel1_one_pix_ce", one_if.pix_ce, 1);
    step();
    check("rel2_x", big_if.x, 1);
    check("rel2_pix_ce", big_if.pix_ce, 1);
    check("rel2_sm_x", sm_if.x, 1);
    step();
    check("rel3_x", big_if.x, 1);
    check("rel3_pix_ce", big_if.pix_ce, 0);
    check("rel3_line_start", big_if.line_start, 0);
    check("rel3_one_x", one_if.x, 3);

    // hsync falls with x=656 and stays low 96 pixels = 192 clks
    k = 0;
    while (big_if.x != 10'd656 && k < 3000) begin step(); k++; end
    check("wait_x656", k < 3000, 1);
    check("h656_hsync", big_if.hsync, 0);
    check("h656_video_on", big_if.video_on, 0);
    n = 0;
    while (big_if.hsync == 1'b0 && n < 1000) begin step(); n++; end
    check("hsync_low_clks", n, 192);
    check("hsync_end_x", big_if.x, 752);

    // Line period and visible clocks per line
    k = 0;
    while (!big_if.line_start && k < 3000) begin step(); k++; end
    check("wait_line_start", k < 3000, 1);
    check("ls_y", big_if.y, 1);
    check("ls_x", big_if.x, 0);
    n = 0;
    von = 0;
    do begin
      step();
      n++;
      if (big_if.video_on) von++;
    end while (!big_if.line_start && n < 4000);
    check("line_period", n, 1600);
    check("line_video_on", von, 1280);
    check("ls2_y", big_if.y, 2);

    // Asynchronous reset mid-line
    k = 0;
    while (big_if.x != 10'd300 && k < 3000) begin step(); k++; end
    check("wait_x300", k < 3000, 1);
    rst = 1'b1;
    #1;
    check("mrst_x", big_if.x, 0);
    check("mrst_y", big_if.y, 0);
    check("mrst_hsync", big_if.hsync, 1);
    check("mrst_video_on", big_if.video_on, 1);
    check("mrst_pix_ce", big_if.pix_ce, 0);
    step();
    rst = 1'b0;
    step();
    check("mrel1_x", big_if.x, 0);
    step();
    check("mrel2_x", big_if.x, 1);

    // Small raster frame wrap (15,7) -> (0,0)
    k = 0;
    px = sm_if.x;
    py = sm_if.y;
    while (!sm_if.frame_start && k < 1000) begin
      px = sm_if.x;
      py = sm_if.y;
      step();
      k++;
    end
    check("wait_frame_start", k < 1000, 1);
    check("wrap_prev_x", px, 15);
    check("wrap_prev_y", py, 7);
    check("wrap_x", sm_if.x, 0);
    check("wrap_y", sm_if.y, 0);
    check("wrap_line_start", sm_if.line_start, 1);

    // One small frame: period, blanking, sync widths
    n = 0; von = 0; vlow = 0; hlow = 0; hlow_v = 0; ls = 0;
    do begin
      step();
      n++;
      if (sm_if.video_on) von++;
      if (!sm_if.vsync) vlow++;
      if (!sm_if.hsync) hlow++;
      if (!sm_if.hsync && !sm_if.vsync) hlow_v++;
      if (sm_if.line_start) ls++;
    end while (!sm_if.frame_start && n < 1000);
    check("frame_period", n, 256);
    check("frame_video_on", von, 64);
    check("frame_vsync_low", vlow, 64);
    check("frame_hsync_low", hlow, 48);
    check("hsync_in_vsync", hlow_v, 12);
    check("frame_line_starts", ls, 8);

    // CLK_DIV=1 raster, restarted from reset
    rst = 1'b1;
    #1;
`ifdef VGA_TIMING_FRAME_CNT_EN
    check("fc_rst", one_if.frame_cnt, 0);
`endif
    step();
    rst = 1'b0;
    n = 0;
    pce = 0;
    do begin
      step();
      n++;
      if (one_if.pix_ce) pce++;
    end while (!one_if.frame_start && n < 500);
    check("one_frame_period", n, 128);
    check("one_pix_ce", pce, 128);
`ifdef VGA_TIMING_FRAME_CNT_EN
    check("fc_1", one_if.frame_cnt, 1);
`endif
    n = 0;
    do begin step(); n++; end while (!one_if.line_start && n < 500);
    check("one_line_period", n, 16);
    k = 0;
    while (!one_if.frame_start && k < 500) begin step(); k++; end
    check("one_wait_fs2", k < 500, 1);
`ifdef VGA_TIMING_FRAME_CNT_EN
    check("fc_2", one_if.frame_cnt, 2);
`endif
    step();
    k = 0;
    while (!one_if.frame_start && k < 500) begin step(); k++; end
    check("one_wait_fs3", k < 500, 1);
`ifdef VGA_TIMING_FRAME_CNT_EN
    check("fc_3", one_if.frame_cnt, 3);
    rst = 1'b1;
    #1;
    check("fc_rst2", one_if.frame_cnt, 0);
    step();
    rst = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
